// File: rtl/pulse_train_gen_if.sv
// Register/strobe bus of pulse_train_gen: shared write data, P/N readback, control strobes
// and the registered tick/busy/done outputs.
interface pulse_train_gen_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] period_data_out;
    logic [WIDTH-1:0] count_data_out;
    logic             period_load;
    logic             count_load;
    logic             start;
    logic             stop;
    logic             tick_out;
    logic             busy;
    logic             done;

    modport master (
        output data_in, period_load, count_load, start, stop,
        input  period_data_out, count_data_out, tick_out, busy, done
    );

    modport slave (
        input  data_in, period_load, count_load, start, stop,
        output period_data_out, count_data_out, tick_out, busy, done
    );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: N pulses of max(P,2) cycles each on tick_out, then done.
// Optional macro PULSE_GEN_AUTORELOAD_EN reloads N from the last loaded count and runs until stop.
module pulse_train_gen #(
    parameter int WIDTH = 8
) (
    input  logic              sysclk,
    input  logic              sysreset_n,
    pulse_train_gen_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_pe;
    logic [WIDTH-1:0] r_phase;
    logic             r_tick;
    logic             r_busy;
    logic             r_done;
`ifdef PULSE_GEN_AUTORELOAD_EN
    logic [WIDTH-1:0] r_n0;
`endif

    logic [WIDTH-1:0] w_pe_cur;
    logic [WIDTH-1:0] w_n_nx;
    logic [WIDTH-1:0] w_n_base;
    logic [WIDTH-1:0] w_pe_nx;
    logic [WIDTH-1:0] w_phase_nx;
    logic             w_phase_end;
    logic             w_start_pulse;
    logic             w_done_nx;

    assign w_pe_cur    = (r_p < WIDTH'(2)) ? WIDTH'(2) : r_p;
    assign w_phase_end = (r_phase == WIDTH'(1));

    always_comb begin
        w_state_nx    = r_state;
        w_n_base      = r_n;
        w_n_nx        = r_n;
        w_pe_nx       = r_pe;
        w_phase_nx    = r_phase;
        w_start_pulse = 1'b0;
        w_done_nx     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop && (r_n != '0))
                    w_start_pulse = 1'b1;
            end
            S_HIGH: begin
                if (bus.stop) begin
                    w_state_nx = S_IDLE;
                    w_phase_nx = '0;
                end else if (w_phase_end) begin
                    w_state_nx = S_LOW;
                    w_phase_nx = r_pe - (r_pe >> 1);
                end else begin
                    w_phase_nx = r_phase - WIDTH'(1);
                end
            end
            S_LOW: begin
                if (bus.stop) begin
                    w_state_nx = S_IDLE;
                    w_phase_nx = '0;
                end else if (w_phase_end) begin
                    if (r_n != '0) begin
                        w_start_pulse = 1'b1;
`ifdef PULSE_GEN_AUTORELOAD_EN
                    end else if (r_n0 != '0) begin
                        // done still strobes, but the next pulse follows with no gap
                        w_done_nx     = 1'b1;
                        w_n_base      = r_n0;
                        w_start_pulse = 1'b1;
`endif
                    end else begin
                        w_state_nx = S_IDLE;
                        w_phase_nx = '0;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_phase_nx = r_phase - WIDTH'(1);
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_phase_nx = '0;
            end
        endcase

        // Pulse start: shadow Pe so mid-pulse period writes only affect later pulses
        if (w_start_pulse) begin
            w_state_nx = S_HIGH;
            w_pe_nx    = w_pe_cur;
            w_phase_nx = w_pe_cur >> 1;
            w_n_nx     = w_n_base - WIDTH'(1);
        end
        if (bus.count_load)
            w_n_nx = bus.data_in;
    end

    always_ff @(posedge sysclk) begin
        if (!sysreset_n) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_n     <= '0;
            r_pe    <= '0;
            r_phase <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_n     <= w_n_nx;
            r_pe    <= w_pe_nx;
            r_phase <= w_phase_nx;
            r_tick  <= (w_state_nx == S_HIGH);
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_done_nx;
            if (bus.period_load)
                r_p <= bus.data_in;
        end
    end

`ifdef PULSE_GEN_AUTORELOAD_EN
    always_ff @(posedge sysclk) begin
        if (!sysreset_n)
            r_n0 <= '0;
        else if (bus.count_load)
            r_n0 <= bus.data_in;
    end
`endif

    assign bus.period_data_out = r_p;
    assign bus.count_data_out  = r_n;
    assign bus.tick_out        = r_tick;
    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Programmable pulse-train source: emits exactly N pulses on tick_out, each P sysclk cycles long, then stops.
- Producer end of the event-counting peripherals. tick_out drives their counter_tick input, or a GPIO, so counters and timers can be stimulated and calibrated from firmware.
- Exposes two read/write registers (period, remaining count) plus start/stop strobes, all on the shared WIDTH-bit data_in bus.

Parameters:
WIDTH, `WW, width of the data bus, period register and count register.

Ports:
sysclk  in  1  system clock; all logic on its rising edge.
sysreset_n  in  1  synchronous, active-low reset.
data_in  in  WIDTH  shared write data for period_load and count_load.
period_data_out  out  WIDTH  current period register value P.
period_load  in  1  P <= data_in on this clock.
count_data_out  out  WIDTH  pulses remaining, N (not yet started).
count_load  in  1  N <= data_in on this clock.
start  in  1  one-cycle strobe; begins the train.
stop  in  1  one-cycle strobe; aborts the train.
tick_out  out  1  registered pulse output.
busy  out  1  high while the train is running.
done  out  1  one-cycle strobe when the train completes normally.

Behaviour:
- Reset (sysreset_n low at a clock edge):
  - P=0, N=0, state IDLE.
  - tick_out=0, busy=0, done=0, phase counter=0.
  - Applies from any state, including mid-pulse.
- Effective period Pe:
  - Pe = max(P, 2), latched into a shadow register at the start of each pulse.
  - High phase H = Pe>>1 cycles; low phase L = Pe-H cycles.
  - So H>=1 and L>=1.
- States:
  - IDLE: tick_out=0, busy=0.
    - start && !stop && N!=0 -> HIGH; latch Pe; N<=N-1.
    - start with N==0 is ignored and done is not asserted.
  - HIGH: tick_out=1 for exactly H cycles, then -> LOW.
  - LOW: tick_out=0 for exactly L cycles, then:
    - N!=0 -> HIGH (latch Pe, N<=N-1);
    - N==0 -> IDLE with done=1 for one cycle.
  - Consecutive pulses are seamless: no idle cycle between them.
- Timing:
  - start sampled at edge t -> tick_out=1 and busy=1 from t+1.
  - busy is 1 in HIGH and LOW; it drops in the same cycle done rises.
  - Last low cycle at t+k -> done=1 at t+k+1.
- stop:
  - In HIGH or LOW -> IDLE next cycle; tick_out=0, done=0.
  - N keeps its remaining value, so a later start resumes the remaining pulses.
  - Simultaneous start and stop: stop wins.
- start while busy: ignored.
- period_load while busy: P updates immediately (readback shows the new value); the new Pe applies from the next pulse start.
- count_load:
  - Overwrites N at any time.
  - Same-cycle count_load and decrement: load wins, no decrement.
  - Loading 0 while busy finishes the current pulse, then asserts done.
- Arithmetic: N only decrements when nonzero, so it never wraps. The phase counter is WIDTH bits and counts down to 1.
- Outputs tick_out, busy and done are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro PULSE_GEN_AUTORELOAD_EN.
- Defined:
  - An extra register N0 captures data_in on every count_load.
  - When the last pulse's LOW phase ends, done strobes for one cycle and N reloads from N0, followed seamlessly by the next pulse's HIGH phase. The train continues until stop.
  - busy stays 1 throughout.
  - If N0==0, behaviour is as without the macro.
- Undefined: no N0 register; the train ends in IDLE as above.

Test Plan:
- Reset then readback -> period_data_out=0, count_data_out=0, tick_out=0, busy=0.
- Load P=4, N=3, start at t -> tick_out high t+1..t+2 and low t+3..t+4, repeated three times; done=1 at t+13; count_data_out=0; busy low from t+13.
- P=5, N=1 -> one pulse 2 cycles high, 3 cycles low. Separately, P=0 and P=1 -> pulses behave as Pe=2 (1 high, 1 low).
- P=6, N=10, start, then stop during the 3rd pulse -> tick_out=0 the next cycle, no done, count_data_out=7. A second start emits exactly 7 more pulses, then done.
- Running with P=4: period_load 8 mid-pulse -> the current pulse stays 4 cycles, subsequent pulses are 8. count_load 0 mid-pulse -> the current pulse completes, then done. Start+stop in the same cycle from IDLE -> stays IDLE.
- PULSE_GEN_AUTORELOAD_EN: P=2, N=2 -> continuous pulses with done every 4 cycles and busy constantly 1; stop halts the train. Assert sysreset_n=0 mid-HIGH -> all outputs 0 next cycle.
